// File: rtl/unsinttodouble_if.sv
// Handshake bundle for the unsigned-int to double converter: enable and operand in,
// double result and completion pulse out.
interface unsinttodouble_if;
   logic        en;
   logic [31:0] input_a;
   logic [63:0] output_z;
   logic        complete;

   modport master (
      output en,
      output input_a,
      input  output_z,
      input  complete
   );

   modport slave (
      input  en,
      input  input_a,
      output output_z,
      output complete
   );
endinterface

// File: rtl/unsinttodouble.sv
// Multi-cycle 32-bit unsigned integer to IEEE-754 double converter.
// Normalises by shifting the operand left one bit per cycle until bit 31 is set.
// Every 32-bit value is exact in a double, so there is no rounding stage.
module unsinttodouble (
   input  logic           clk,
   input  logic           rst,
   unsinttodouble_if.slave bus
);

   localparam logic [2:0] StGetA         = 3'd0;
   localparam logic [2:0] StSpecialCases = 3'd1;
   localparam logic [2:0] StNormalise    = 3'd2;
   localparam logic [2:0] StPack         = 3'd3;
   localparam logic [2:0] StPutZ         = 3'd4;

   // 1023 bias + 31: exponent when the operand's MSB is already in bit 31
   localparam logic [10:0] ExpStart = 11'd1054;

   logic [2:0]  r_state;
   logic [31:0] r_a;
   logic [31:0] r_m;
   logic [10:0] r_e;
   logic [63:0] r_z;
   logic [63:0] r_output_z;
   logic        r_complete;

   logic        w_abort;

   // A changed operand mid-conversion restarts from get_a without publishing anything
   assign w_abort = (r_state != StGetA) && (bus.input_a != r_a);

   assign bus.output_z = r_output_z;
   assign bus.complete = r_complete;

   // Conversion FSM: reset beats enable, enable beats abort, abort beats state transitions
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= StGetA;
         r_output_z <= 64'd0;
         r_complete <= 1'b0;
      end else if (!bus.en) begin
         r_state    <= StGetA;
         r_output_z <= 64'd0;
         r_complete <= 1'b0;
      end else if (w_abort) begin
         r_state <= StGetA;
      end else begin
         case (r_state)
            StGetA: begin
               r_a        <= bus.input_a;
               r_complete <= 1'b0;
               r_state    <= StSpecialCases;
            end
            StSpecialCases: begin
               if (r_a == 32'd0) begin
                  r_z     <= 64'd0;
                  r_state <= StPutZ;
               end else begin
                  r_m     <= r_a;
                  r_e     <= ExpStart;
                  r_state <= StNormalise;
               end
            end
            StNormalise: begin
               if (!r_m[31]) begin
                  r_m <= {r_m[30:0], 1'b0};
                  r_e <= r_e - 11'd1;
               end else begin
                  r_state <= StPack;
               end
            end
            StPack: begin
               // Hidden bit m[31] is implicit in the double format and dropped here
               r_z     <= {1'b0, r_e, r_m[30:0], 21'd0};
               r_state <= StPutZ;
            end
            StPutZ: begin
               r_output_z <= r_z;
               r_complete <= 1'b1;
               r_state    <= StGetA;
            end
            default: begin
               r_state <= StGetA;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_unsinttodouble.sv
// Randomised self-checking bench for unsinttodouble against an arithmetic reference model.
module tb_unsinttodouble;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   unsinttodouble_if u_if ();

   unsinttodouble u_dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: locate the MSB, exponent = bias + MSB index, fraction = bits below the MSB
   function automatic logic [63:0] ref_dbl(input logic [31:0] v);
      int                 p;
      logic [63:0]        x;
      logic [10:0]        e;
      if (v == 32'd0) return 64'd0;
      p = 0;
      for (int i = 0; i < 32; i++) if (v[i]) p = i;
      e = 11'(1023 + p);
      x = 64'(v) << (52 - p);
      return {1'b0, e, x[51:0]};
   endfunction

   function automatic int ref_lat(input logic [31:0] v);
      int p;
      if (v == 32'd0) return 3;
      p = 0;
      for (int i = 0; i < 32; i++) if (v[i]) p = i;
      return (31 - p) + 5;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // One rising edge, leaving time at the following falling edge for sampling/driving
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Edges until complete is seen high (1 = first edge); -1 on timeout
   task automatic wait_complete(output int n, output logic [63:0] z);
      bit found;
      found = 1'b0;
      n     = -1;
      z     = 64'hx;
      for (int i = 1; i <= 100 && !found; i++) begin
         step();
         if (u_if.complete) begin
            found = 1'b1;
            n     = i;
            z     = u_if.output_z;
         end
      end
   endtask

   task automatic convert(input logic [31:0] v);
      int          n;
      logic [63:0] z;
      u_if.en      = 1'b0;
      u_if.input_a = v;
      step();
      u_if.en = 1'b1;
      wait_complete(n, z);
      check($sformatf("lat_%h", v), 64'(n), 64'(ref_lat(v)));
      check($sformatf("val_%h", v), z, ref_dbl(v));
      step();
      check($sformatf("pulse_once_%h", v), 64'(u_if.complete), 64'd0);
      check($sformatf("hold_%h", v), u_if.output_z, ref_dbl(v));
      // Free-running: next pulse one full period after the previous one
      wait_complete(n, z);
      check($sformatf("period_%h", v), 64'(n), 64'(ref_lat(v) - 1));
      check($sformatf("rep_val_%h", v), z, ref_dbl(v));
   endtask

   initial begin
      int          n;
      logic [63:0] z;
      logic [31:0] v;
      n_tests      = 0;
      n_fail       = 0;
      rst          = 1'b0;
      u_if.en      = 1'b1;
      u_if.input_a = 32'h1234_5678;
      @(negedge clk);
      step();
      step();
      check("rst_z", u_if.output_z, 64'd0);
      check("rst_c", 64'(u_if.complete), 64'd0);
      rst = 1'b1;

      // Directed corner values
      convert(32'h0000_0001);
      convert(32'h0000_0000);
      convert(32'hFFFF_FFFF);
      convert(32'h8000_0000);
      convert(32'h0000_0005);

      // Randomised operands spread over all leading-zero counts
      for (int k = 0; k < 24; k++) begin
         v = $urandom >> $urandom_range(0, 31);
         if (k % 8 == 7) v = 32'd0;
         convert(v);
      end

      // Operand change during normalise aborts and restarts
      u_if.en      = 1'b0;
      u_if.input_a = 32'h0000_0001;
      step();
      u_if.en = 1'b1;
      for (int i = 0; i < 5; i++) step();
      u_if.input_a = 32'h8000_0000;
      wait_complete(n, z);
      check("abort_lat", 64'(n), 64'd6);
      check("abort_val", z, 64'h41E0_0000_0000_0000);

      // Reset mid-normalise
      u_if.en      = 1'b0;
      u_if.input_a = 32'h0000_0001;
      step();
      u_if.en = 1'b1;
      for (int i = 0; i < 5; i++) step();
      rst = 1'b0;
      step();
      check("midrst_z", u_if.output_z, 64'd0);
      check("midrst_c", 64'(u_if.complete), 64'd0);
      rst = 1'b1;
      wait_complete(n, z);
      check("midrst_lat", 64'(n), 64'd36);
      check("midrst_val", z, 64'h3FF0_0000_0000_0000);

      // Enable drop after a completed conversion
      u_if.en      = 1'b0;
      u_if.input_a = 32'hFFFF_FFFF;
      step();
      u_if.en = 1'b1;
      wait_complete(n, z);
      check("en_pre_val", z, 64'h41EF_FFFF_FFE0_0000);
      u_if.en = 1'b0;
      step();
      check("en_low_z", u_if.output_z, 64'd0);
      check("en_low_c", 64'(u_if.complete), 64'd0);
      u_if.en = 1'b1;
      wait_complete(n, z);
      check("en_re_lat", 64'(n), 64'd5);
      check("en_re_val", z, 64'h41EF_FFFF_FFE0_0000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
